// File: rtl/ft800_spi_pkg.sv
// Shared FT800 SPI constants, FSM state encoding and frame-length helper used by the
// SPI engine and ft800_interface.
package ft800_spi_pkg;

   localparam logic [1:0] FT800_OP_READ    = 2'b00;
   localparam logic [1:0] FT800_OP_WRITE   = 2'b10;
   localparam int unsigned FT800_READ_BITS  = 48;
   localparam int unsigned FT800_WRITE_BITS = 40;
   localparam int unsigned FT800_HOST_BITS  = 24;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StShiftHi,
      StShiftLo,
      StHold
   } spi_state_e;

   function automatic logic [5:0] clamp_bits(input logic [5:0] bits, input int unsigned max_bits);
      return (32'(bits) > max_bits) ? 6'(max_bits) : bits;
   endfunction

endpackage

// File: rtl/ft800_spi_if.sv
// Host-side request/result bundle plus the four SPI pins of the FT800 engine.
interface ft800_spi_if #(
   parameter int unsigned FRAME_W = 48
) ();

   logic               start;
   logic [FRAME_W-1:0] tx_word;
   logic [5:0]         tx_bits;
   logic               busy;
   logic               done;
   logic [15:0]        rx_data;
   logic               mosi;
   logic               miso;
   logic               chip_select;
   logic               spi_clk;

   modport master (
      output start, tx_word, tx_bits, miso,
      input  busy, done, rx_data, mosi, chip_select, spi_clk
   );

   modport slave (
      input  start, tx_word, tx_bits, miso,
      output busy, done, rx_data, mosi, chip_select, spi_clk
   );

endinterface

// File: rtl/ft800_spi_tick.sv
// Half-period tick generator: one-cycle pulse every CLK_DIV enabled cycles, restarted
// whenever the enable drops.
module ft800_spi_tick #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

   logic [CntW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || (cnt_q == '0)) begin
         cnt_d = Reload;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= Reload;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/ft800_spi_engine.sv
// Mode-0 SPI master for FT800 frames: shifts up to FRAME_W bits MSB first and collects
// the last 16 miso bits into rx_data.
module ft800_spi_engine
   import ft800_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned FRAME_W = 48
) (
   input logic         clk,
   input logic         rst,
   ft800_spi_if.slave  bus
);

   spi_state_e         state_d, state_q;
   logic [FRAME_W-1:0] shreg_d, shreg_q;
   logic [5:0]         bits_left_d, bits_left_q;
   logic [15:0]        rx_sh_d, rx_sh_q;
   logic [15:0]        rx_data_d, rx_data_q;
   logic               mosi_d, mosi_q;
   logic               cs_d, cs_q;
   logic               sclk_d, sclk_q;
   logic               busy_d, busy_q;
   logic               done_d, done_q;
   logic               tick;
   logic               accept;
   logic [5:0]         n_bits;

   // The done cycle is still StIdle, so done_q blocks a start landing in it.
   assign accept = (state_q == StIdle) && !done_q && bus.start;
   assign n_bits = clamp_bits(bus.tx_bits, FRAME_W);

   ft800_spi_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .en_i  (state_q != StIdle),
      .tick_o(tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (accept && (n_bits != 6'd0)) state_d = StSetup;
         StSetup:   if (tick) state_d = StShiftHi;
         StShiftHi: if (tick) state_d = (bits_left_q == 6'd1) ? StHold : StShiftLo;
         StShiftLo: if (tick) state_d = StShiftHi;
         StHold:    if (tick) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      shreg_d     = shreg_q;
      bits_left_d = bits_left_q;
      rx_sh_d     = rx_sh_q;
      rx_data_d   = rx_data_q;
      mosi_d      = mosi_q;
      cs_d        = cs_q;
      sclk_d      = sclk_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (n_bits == 6'd0) begin
                  done_d = 1'b1;
               end else begin
                  cs_d        = 1'b1;
                  busy_d      = 1'b1;
                  mosi_d      = bus.tx_word[FRAME_W-1];
                  shreg_d     = bus.tx_word << 1;
                  bits_left_d = n_bits;
               end
            end
         end
         StSetup, StShiftLo: begin
            if (tick) begin
               sclk_d  = 1'b1;
               rx_sh_d = {rx_sh_q[14:0], bus.miso};
            end
         end
         StShiftHi: begin
            if (tick) begin
               sclk_d      = 1'b0;
               bits_left_d = bits_left_q - 6'd1;
               if (bits_left_q == 6'd1) begin
                  mosi_d = 1'b0;
               end else begin
                  mosi_d  = shreg_q[FRAME_W-1];
                  shreg_d = shreg_q << 1;
               end
            end
         end
         StHold: begin
            if (tick) begin
               cs_d      = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_sh_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q     <= '0;
         bits_left_q <= '0;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         mosi_q      <= 1'b0;
         cs_q        <= 1'b0;
         sclk_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         bits_left_q <= bits_left_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         mosi_q      <= mosi_d;
         cs_q        <= cs_d;
         sclk_q      <= sclk_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.mosi        = mosi_q;
   assign bus.chip_select = cs_q;
   assign bus.spi_clk     = sclk_q;

endmodule
